// File: rtl/gen_sink_pkg.sv
// Shared types and default widths for the generator sink/accumulator.
package gen_sink_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_START   = 2'd1,
      S_COLLECT = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam int DEF_ACC_W   = 48;
   localparam int DEF_CNT_W   = 16;
   localparam int DEF_TIMEOUT = 1024;
   localparam int DATA_W      = 32;

endpackage

// File: rtl/gen_sink_stats.sv
// Sample statistics datapath: wrapping signed sum, saturating count, min/max and sticky overflow.
module gen_sink_stats
   import gen_sink_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clear_i,
   input  logic                     xfer_i,
   input  logic signed [DATA_W-1:0] data_i,
   output logic signed [ACC_W-1:0]  sum_o,
   output logic        [CNT_W-1:0]  count_o,
   output logic signed [DATA_W-1:0] min_o,
   output logic signed [DATA_W-1:0] max_o,
   output logic                     ovf_o
);

   // One bit wider than either operand so the exact sum is always representable.
   localparam int EXT_W = ((ACC_W > DATA_W) ? ACC_W : DATA_W) + 1;

   logic signed [ACC_W-1:0]  sum_q, sum_d;
   logic        [CNT_W-1:0]  count_q;
   logic signed [DATA_W-1:0] min_q, max_q;
   logic                     ovf_q;
   logic signed [EXT_W-1:0]  full_sum;
   logic                     sum_ovf, cnt_sat, first;

   always_comb begin
      full_sum = EXT_W'(sum_q) + EXT_W'(data_i);
      sum_d    = full_sum[ACC_W-1:0];
      sum_ovf  = (EXT_W'(sum_d) != full_sum);
      cnt_sat  = &count_q;
      first    = (count_q == '0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sum_q   <= '0;
         count_q <= '0;
         min_q   <= '0;
         max_q   <= '0;
         ovf_q   <= 1'b0;
      end else if (clear_i) begin
         sum_q   <= '0;
         count_q <= '0;
         min_q   <= '0;
         max_q   <= '0;
         ovf_q   <= 1'b0;
      end else if (xfer_i) begin
         sum_q <= sum_d;
         if (!cnt_sat) count_q <= count_q + CNT_W'(1);
         if (first || data_i < min_q) min_q <= data_i;
         if (first || data_i > max_q) max_q <= data_i;
         ovf_q <= ovf_q | sum_ovf | cnt_sat;
      end
   end

   assign sum_o   = sum_q;
   assign count_o = count_q;
   assign min_o   = min_q;
   assign max_o   = max_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/gen_sink_accum.sv
// Caller end of a generator ready/valid stream: runs a collection, accumulates stats, aborts on idle timeout.
// Optional GEN_SINK_THROTTLE_EN toggles gen__ready every COLLECT cycle to exercise back-pressure.
module gen_sink_accum
   import gen_sink_pkg::*;
#(
   parameter int ACC_W   = DEF_ACC_W,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                     _clock,
   input  logic                     _reset_n,
   input  logic                     _start,
   output logic                     gen__start,
   output logic                     gen__ready,
   input  logic                     gen__valid,
   input  logic                     gen__done,
   input  logic signed [DATA_W-1:0] gen_0,
   output logic                     _busy,
   output logic                     _done,
   output logic signed [ACC_W-1:0]  sum,
   output logic        [CNT_W-1:0]  count,
   output logic signed [DATA_W-1:0] min_v,
   output logic signed [DATA_W-1:0] max_v,
   output logic                     ovf,
   output logic                     timeout
);

   localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   state_t            state_q, state_d;
   logic              start_q, ready_q, ready_d, busy_q, done_q, timeout_q;
   logic [IDLE_W-1:0] idle_q;
   logic              clear, xfer, timeout_hit;

   assign clear       = (state_q == S_IDLE) && _start;
   assign xfer        = (state_q == S_COLLECT) && gen__valid && ready_q;
   assign timeout_hit = (TIMEOUT > 0) && !xfer && (idle_q == IDLE_W'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (_start) state_d = S_START;
         S_START:   state_d = S_COLLECT;
         S_COLLECT: if (gen__done || timeout_hit) state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
`ifdef GEN_SINK_THROTTLE_EN
      // First COLLECT cycle is ready, then alternate.
      ready_d = (state_d == S_COLLECT) && !((state_q == S_COLLECT) && ready_q);
`else
      ready_d = (state_d == S_COLLECT);
`endif
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge _clock or negedge _reset_n) begin
      if (!_reset_n) begin
         state_q   <= S_IDLE;
         start_q   <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         idle_q    <= '0;
      end else begin
         state_q <= state_d;
         start_q <= (state_d == S_START);
         ready_q <= ready_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_DONE);
         if (state_q == S_COLLECT && !xfer && TIMEOUT > 0) idle_q <= idle_q + IDLE_W'(1);
         else idle_q <= '0;
         if (clear) timeout_q <= 1'b0;
         else if (state_q == S_COLLECT && timeout_hit) timeout_q <= 1'b1;
      end
   end

   gen_sink_stats #(
      .ACC_W(ACC_W),
      .CNT_W(CNT_W)
   ) u_stats (
      .clk_i  (_clock),
      .rst_ni (_reset_n),
      .clear_i(clear),
      .xfer_i (xfer),
      .data_i (gen_0),
      .sum_o  (sum),
      .count_o(count),
      .min_o  (min_v),
      .max_o  (max_v),
      .ovf_o  (ovf)
   );

   assign gen__start = start_q;
   assign gen__ready = ready_q;
   assign _busy      = busy_q;
   assign _done      = done_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_gen_sink_accum.sv
// Bench for gen_sink_accum: table vectors, random runs vs. a queue-based model, timeout, reset and narrow-width corners.
module tb_gen_sink_accum;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start2 = 1'b0;
   logic valid = 1'b0, gdone = 1'b0;
   logic signed [31:0] data = '0;

   logic gs, gr, busy, done, ovf, tmo;
   logic signed [47:0] sum;
   logic [15:0] cnt;
   logic signed [31:0] mn, mx;

   logic gs2, gr2, busy2, done2, ovf2, tmo2;
   logic signed [7:0] sum2;
   logic [1:0] cnt2;
   logic signed [31:0] mn2, mx2;

   gen_sink_accum #(.ACC_W(48), .CNT_W(16), .TIMEOUT(16)) dut (
      ._clock(clk), ._reset_n(rst_n), ._start(start),
      .gen__start(gs), .gen__ready(gr), .gen__valid(valid), .gen__done(gdone), .gen_0(data),
      ._busy(busy), ._done(done), .sum(sum), .count(cnt), .min_v(mn), .max_v(mx),
      .ovf(ovf), .timeout(tmo));

   gen_sink_accum #(.ACC_W(8), .CNT_W(2), .TIMEOUT(0)) dut2 (
      ._clock(clk), ._reset_n(rst_n), ._start(start2),
      .gen__start(gs2), .gen__ready(gr2), .gen__valid(valid), .gen__done(gdone), .gen_0(data),
      ._busy(busy2), ._done(done2), .sum(sum2), .count(cnt2), .min_v(mn2), .max_v(mx2),
      .ovf(ovf2), .timeout(tmo2));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int done_pulses = 0, done_pulses2 = 0;
   always @(posedge clk) begin
      if (done)  done_pulses  <= done_pulses + 1;
      if (done2) done_pulses2 <= done_pulses2 + 1;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   int samp[$];
   int acc_q[$];

   // Present one sample and hold it until the DUT's ready is seen; optional done on the same edge.
   task automatic send_sample(input int dut, input int v, input bit with_done);
      bit got;
      got = 1'b0;
      valid = 1'b1;
      data = v;
      for (int k = 0; k < 8 && !got; k++) begin
         if (((dut != 0) ? gr2 : gr) === 1'b1) begin
            gdone = with_done;
            got = 1'b1;
         end
         @(negedge clk);
      end
      chk("xfer_ack", longint'(got), 1);
      acc_q.push_back(v);
      valid = 1'b0;
      gdone = 1'b0;
   endtask

   task automatic do_run(input int dut, input bit dwl, input int maxgap);
      int p0;
      acc_q = {};
      p0 = (dut != 0) ? done_pulses2 : done_pulses;
      if (dut != 0) start2 = 1'b1; else start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      start2 = 1'b0;
      if (dut == 0) begin
         chk("start_strobe", longint'(gs), 1);
         chk("start_ready", longint'(gr), 0);
      end
      @(negedge clk);
      foreach (samp[i]) begin
         repeat ($urandom_range(0, maxgap)) @(negedge clk);
         send_sample(dut, samp[i], dwl && (i == samp.size() - 1));
      end
      if (!dwl || samp.size() == 0) begin
         gdone = 1'b1;
         @(negedge clk);
         gdone = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("done_pulses", longint'(((dut != 0) ? done_pulses2 : done_pulses) - p0), 1);
      chk("busy_after", longint'((dut != 0) ? busy2 : busy), 0);
   endtask

   // Reference: per-step two's-complement wrap at 48 bits, saturating count, min/max over accepted queue.
   task automatic check_model(input string name);
      longint ws, nxt;
      bit o;
      int n, emn, emx;
      ws = 0; o = 1'b0; emn = 0; emx = 0;
      n = acc_q.size();
      foreach (acc_q[i]) begin
         nxt = ws + longint'(acc_q[i]);
         ws = (nxt <<< 16) >>> 16;
         if (ws != nxt) o = 1'b1;
         if (i == 0 || acc_q[i] < emn) emn = acc_q[i];
         if (i == 0 || acc_q[i] > emx) emx = acc_q[i];
      end
      if (n > 65535) o = 1'b1;
      chk({name, "_sum"}, $signed(sum), ws);
      chk({name, "_cnt"}, longint'(cnt), (n > 65535) ? 65535 : n);
      chk({name, "_min"}, $signed(mn), emn);
      chk({name, "_max"}, $signed(mx), emx);
      chk({name, "_ovf"}, longint'(ovf), longint'(o));
      chk({name, "_tmo"}, longint'(tmo), 0);
   endtask

   typedef struct {
      int     n;
      int     v[6];
      bit     dwl;
      longint es;
      int     ec;
      int     emn;
      int     emx;
   } vec_t;

   vec_t tbl[4];

   initial begin
      int cyc, p;
      tbl[0] = '{5, '{0, 2, 4, 6, 8, 0}, 1'b0, 20, 5, 0, 8};
      tbl[1] = '{0, '{0, 0, 0, 0, 0, 0}, 1'b0, 0, 0, 0, 0};
      tbl[2] = '{1, '{7, 0, 0, 0, 0, 0}, 1'b1, 7, 1, 7, 7};
      tbl[3] = '{3, '{-5, 10, -20, 0, 0, 0}, 1'b1, -15, 3, -20, 10};

      repeat (3) @(negedge clk);
      chk("rst_sum", $signed(sum), 0);
      chk("rst_cnt", longint'(cnt), 0);
      chk("rst_ready", longint'(gr), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_gstart", longint'(gs), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int t = 0; t < 4; t++) begin
         samp = {};
         for (int j = 0; j < tbl[t].n; j++) samp.push_back(tbl[t].v[j]);
         do_run(0, tbl[t].dwl, 2);
         chk($sformatf("vec%0d_sum", t), $signed(sum), tbl[t].es);
         chk($sformatf("vec%0d_cnt", t), longint'(cnt), tbl[t].ec);
         chk($sformatf("vec%0d_min", t), $signed(mn), tbl[t].emn);
         chk($sformatf("vec%0d_max", t), $signed(mx), tbl[t].emx);
         chk($sformatf("vec%0d_ovf", t), longint'(ovf), 0);
      end

      for (int r = 0; r < 6; r++) begin
         samp = {};
         repeat ($urandom_range(1, 10)) samp.push_back(int'($urandom));
         do_run(0, 1'($urandom_range(0, 1)), 3);
         check_model($sformatf("rand%0d", r));
      end

      // Idle timeout: no valid, no done.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("tmo_cycles", cyc, 18);
      chk("tmo_flag", longint'(tmo), 1);
      chk("tmo_cnt", longint'(cnt), 0);
      @(negedge clk);
      chk("tmo_sticky", longint'(tmo), 1);
      chk("tmo_busy", longint'(busy), 0);

      // Narrow sum and counter.
      samp = '{100, 100};
      do_run(1, 1'b0, 1);
      chk("w8_sum", $signed(sum2), -56);
      chk("w8_cnt", longint'(cnt2), 2);
      chk("w8_ovf", longint'(ovf2), 1);
      samp = '{1, 2, 3, 4, -5};
      do_run(1, 1'b1, 1);
      chk("sat_sum", $signed(sum2), 5);
      chk("sat_cnt", longint'(cnt2), 3);
      chk("sat_min", $signed(mn2), -5);
      chk("sat_max", $signed(mx2), 4);
      chk("sat_ovf", longint'(ovf2), 1);
      samp = '{1, 2};
      do_run(1, 1'b0, 0);
      chk("clr_sum", $signed(sum2), 3);
      chk("clr_ovf", longint'(ovf2), 0);

      // Reset in the middle of a run.
      p = done_pulses;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      send_sample(0, 11, 1'b0);
      send_sample(0, -3, 1'b0);
      send_sample(0, 9, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_sum", $signed(sum), 0);
      chk("mid_rst_cnt", longint'(cnt), 0);
      chk("mid_rst_max", $signed(mx), 0);
      chk("mid_rst_ready", longint'(gr), 0);
      chk("mid_rst_busy", longint'(busy), 0);
      repeat (3) @(negedge clk);
      chk("mid_rst_nodone", longint'(done_pulses - p), 0);
      rst_n = 1'b1;
      @(negedge clk);
      samp = '{0, 2, 4, 6, 8};
      do_run(0, 1'b0, 1);
      chk("post_rst_sum", $signed(sum), 20);
      chk("post_rst_cnt", longint'(cnt), 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
